prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//   Program-mode controller for the SAP-1 core. Accepts a byte stream over a valid/ready
//   handshake, writes it into program RAM at addresses 0..DEPTH-1, and holds the core in
//   clear throughout. Then releases the core to run and tracks it until it halts.
//   Sits between the host/loader interface, the RAM write port and the core's clear line.
// PARAMETERS
//   ADDR_W         4   RAM address width; DEPTH = 2**ADDR_W bytes are loaded per program
//   DATA_W         8   RAM word / stream byte width
//   RELEASE_DLY    2   cycles cpu_clr stays high after the last RAM write (1..15)
// PORTS
//   CLK        in   1       system clock; all logic on rising edge
//   CLR        in   1       synchronous, active-high reset
//   start      in   1       pulse: begin a program load (honoured in IDLE, HALTED, ERROR)
//   in_valid   in   1       stream byte valid
//   in_data    in   DATA_W  stream byte
//   in_ready   out  1       controller accepts in_data this cycle
//   ram_we     out  1       RAM write strobe, one cycle per accepted byte
//   ram_addr   out  ADDR_W  RAM write address
//   ram_wdata  out  DATA_W  RAM write data
//   cpu_hlt    in   1       core has executed HLT
//   cpu_clr    out  1       hold core (PC, IR, sequencer) in clear
//   busy       out  1       state is LOAD, CHECK or RELEASE
//   done       out  1       core released (RUN or HALTED)
//   error      out  1       checksum mismatch (CHECKSUM_EN only; else tied 0)
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, sum=0; in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0,
//     cpu_clr=1, busy=0, done=0, error=0. CLR mid-load aborts: RAM keeps the bytes already
//     written, ram_we is low on the next cycle, and no partial release occurs.
//   States: IDLE -> LOAD -> [CHECK] -> RELEASE -> RUN -> HALTED; ERROR.
//   IDLE: cpu_clr=1. start -> LOAD, cnt=0, sum=0.
//   LOAD: in_ready=1 (decoded from state). A byte is accepted when in_valid & in_ready.
//     The next cycle drives ram_we=1, ram_addr=cnt, ram_wdata=byte (write latency 1).
//     cnt increments; sum += byte (mod 2**DATA_W).
//     Acceptance of byte DEPTH-1 -> CHECK if enabled, else RELEASE. in_ready is low from
//     the next cycle. cnt is ADDR_W+1 bits, so no wrap before the transition.
//     in_valid gaps stall with no writes. start is ignored.
//   RELEASE: cpu_clr=1 for RELEASE_DLY cycles (dly counter). Then RUN.
//   RUN: cpu_clr=0, done=1. start is ignored. cpu_hlt=1 -> HALTED.
//   HALTED: cpu_clr=0 (the OUT register is preserved), done=1. start -> LOAD, with
//     cpu_clr=1 and done=0 from the next cycle.
//   ERROR: cpu_clr=1, error=1. start -> LOAD and error clears.
//   Simultaneous start with cpu_hlt in RUN: cpu_hlt wins (-> HALTED); start is dropped.
//   All outputs are registered except in_ready.
// CONFIGURATION
//   CHECKSUM_EN defined:
//     - After DEPTH bytes, CHECK state: in_ready=1. One extra byte is accepted and is not
//       written to RAM.
//     - If (sum + byte) mod 2**DATA_W == 0 -> RELEASE; else -> ERROR.
//   CHECKSUM_EN undefined: no CHECK state and no sum register; error is tied 0.
// STRUCTURE
//   Shared package sap1_pkg holds:
//     - state encodings (IDLE, LOAD, CHECK, RELEASE, RUN, HALTED, ERROR, 3-bit);
//     - default ADDR_W/DATA_W;
//     - the con_word bit indices, reused by the core top level.
//   One sub-module, prog_load_ctr, combines the cnt/addr counter with the terminal-count
//   flag. The FSM and sum register live in prog_loader.
// TESTING
//   1. Reset, start, 16 bytes 0x00..0x0F back-to-back.
//      -> 16 ram_we pulses, addr 0..15, data = addr.
//      -> cpu_clr falls RELEASE_DLY+1 cycles after the last write; done=1.
//   2. in_valid toggled every other cycle.
//      -> ram_we only on accepted bytes; addr is contiguous; in_ready=0 after byte 15.
//   3. In RUN, assert cpu_hlt -> HALTED with cpu_clr=0 and done=1.
//      Then pulse start -> cpu_clr=1 next cycle, in_ready=1, reload from addr 0.
//   4. CLR asserted after byte 7.
//      -> IDLE next edge, ram_we=0, cpu_clr=1, done=0; bytes 8..15 are never written.
//   5. CHECKSUM_EN: bytes 0x01 x16, checksum 0xF0 -> RUN.
//      Checksum 0xF1 instead -> ERROR, error=1, cpu_clr stays 1.
//      Then start -> error=0.
//   6. start pulsed during LOAD and during RUN -> no state change, no extra writes.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: loader state encoding, default datapath widths
// and control-word bit positions used by the core top level.
package sap1_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_HALTED  = 3'd5,
        ST_ERROR   = 3'd6
    } load_state_t;

    // Bit positions inside the 12-bit con_word; *_N bits are active-low strobes.
    typedef enum int {
        CW_LO_N = 0,
        CW_LB_N = 1,
        CW_EU   = 2,
        CW_SU   = 3,
        CW_EA   = 4,
        CW_LA_N = 5,
        CW_EI_N = 6,
        CW_LI_N = 7,
        CW_CE_N = 8,
        CW_LM_N = 9,
        CW_EP   = 10,
        CW_CP   = 11,
        CON_W   = 12
    } con_bit_t;

endpackage

// File: rtl/prog_load_ctr.sv
// Load address counter with terminal-count flag; one spare MSB keeps the
// count from wrapping before the loader leaves LOAD.
module prog_load_ctr
    import sap1_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'((2**ADDR_W) - 1);

    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign addr = cnt[ADDR_W-1:0];
    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/prog_loader.sv
// SAP-1 program-mode controller: streams DEPTH bytes into program RAM while holding
// the core in clear, then releases it. Define CHECKSUM_EN to require a trailing checksum byte.
module prog_loader
    import sap1_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RELEASE_DLY = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              cpu_hlt,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    load_state_t       state, state_nxt;
    logic [3:0]        dly;
    logic              load_begin;
    logic              wr_en;
    logic              last_byte;
    logic [ADDR_W-1:0] wr_addr;

    assign in_ready = (state == ST_LOAD) || (state == ST_CHECK);
    assign wr_en    = in_valid && (state == ST_LOAD);

    prog_load_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk   (CLK),
        .reset (CLR),
        .clear (load_begin),
        .inc   (wr_en),
        .addr  (wr_addr),
        .last  (last_byte)
    );

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_chk;

    assign sum_chk = sum + in_data;

    always_ff @(posedge CLK) begin
        if (CLR || load_begin) begin
            sum <= '0;
        end else if (wr_en) begin
            sum <= sum + in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            error <= 1'b0;
        end else begin
            error <= (state_nxt == ST_ERROR);
        end
    end
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        load_begin = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    state_nxt  = ST_LOAD;
                    load_begin = 1'b1;
                end
            end
            ST_LOAD: begin
                if (wr_en && last_byte) begin
`ifdef CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_RELEASE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            ST_CHECK: begin
                if (in_valid) begin
                    state_nxt = (sum_chk == '0) ? ST_RELEASE : ST_ERROR;
                end
            end
`endif
            ST_RELEASE: begin
                if (dly == 4'(RELEASE_DLY)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A halt in the same cycle as start takes priority; start is dropped.
                if (cpu_hlt) begin
                    state_nxt = ST_HALTED;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= ST_IDLE;
            dly       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_clr   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state   <= state_nxt;
            dly     <= (state == ST_RELEASE) ? dly + 4'd1 : 4'd0;
            ram_we  <= wr_en;
            if (wr_en) begin
                ram_addr  <= wr_addr;
                ram_wdata <= in_data;
            end
            cpu_clr <= !(state_nxt inside {ST_RUN, ST_HALTED});
            done    <= (state_nxt inside {ST_RUN, ST_HALTED});
            busy    <= (state_nxt inside {ST_LOAD, ST_CHECK, ST_RELEASE});
        end
    end

endmodule
